// File: rtl/door_access_pkg.sv
// Shared types, default constants and width helpers for the keypad door controller.
package door_access_pkg;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    MENU  = 2'd1,
    OPEN  = 2'd2,
    ALARM = 2'd3
  } door_state_e;

  localparam int                    DEF_PW_WIDTH       = 14;
  localparam logic [DEF_PW_WIDTH-1:0] DEF_PW           = 14'd1111;
  localparam int                    DEF_MAX_ATTEMPTS   = 3;
  localparam int                    DEF_UNLOCK_CYCLES  = 100;
  localparam int                    DEF_LOCKOUT_CYCLES = 1000;

  // Width of the consecutive-failure counter: must hold 0..max_attempts.
  function automatic int cnt_w(input int max_attempts);
    return $clog2(max_attempts + 1);
  endfunction

  // Width of the shared countdown timer: must hold 0..max(a,b)-1.
  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/door_access_ctrl_rise_edge_det.sv
// Single-bit rising-edge qualifier: registered copy of the level, AND-NOT.
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/door_access_ctrl.sv
// Keypad door controller: password check, menu, timed unlock, alarm.
// Optional timed alarm lockout is compiled in with `define DOOR_ALARM_LOCKOUT_EN.
module door_access_ctrl
  import door_access_pkg::*;
#(
  parameter int                  PW_WIDTH       = DEF_PW_WIDTH,
  parameter logic [PW_WIDTH-1:0] DEFAULT_PW     = DEF_PW,
  parameter int                  MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int                  UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int                  LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              submit,
  input  logic [PW_WIDTH-1:0]               password_in,
  input  logic                              change_password,
  input  logic [PW_WIDTH-1:0]               new_password,
  input  logic                              unlock_button,
  input  logic                              ms_button,
  output logic                              unlock_signal,
  output logic                              lock_signal,
  output logic                              alarm_signal,
  output logic [cnt_w(MAX_ATTEMPTS)-1:0]    fail_count
);

  localparam int CNT_W = cnt_w(MAX_ATTEMPTS);
  localparam int TMR_W = timer_w(UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam logic [TMR_W-1:0] UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT   = CNT_W'(MAX_ATTEMPTS);
`ifdef DOOR_ALARM_LOCKOUT_EN
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`endif

  logic submit_rise, change_rise, unlock_rise, ms_rise;

  rise_edge_det u_submit_det (
    .clk   (clk),
    .reset (reset),
    .level (submit),
    .rise  (submit_rise)
  );

  rise_edge_det u_change_det (
    .clk   (clk),
    .reset (reset),
    .level (change_password),
    .rise  (change_rise)
  );

  rise_edge_det u_unlock_det (
    .clk   (clk),
    .reset (reset),
    .level (unlock_button),
    .rise  (unlock_rise)
  );

  rise_edge_det u_ms_det (
    .clk   (clk),
    .reset (reset),
    .level (ms_button),
    .rise  (ms_rise)
  );

  door_state_e         state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [PW_WIDTH-1:0] pw_q, pw_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // The relock and (optional) lockout countdowns share one timer: they are
  // never live at the same time since they belong to different states.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    unique case (state_q)
      ENTRY: begin
        if (submit_rise) begin
          if (password_in == pw_q) begin
            state_d = MENU;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LIMIT) begin
              state_d = ALARM;
`ifdef DOOR_ALARM_LOCKOUT_EN
              tmr_d   = LOCKOUT_LOAD;
`endif
            end
          end
        end
      end
      MENU: begin
        if (ms_rise) begin
          state_d = ENTRY;
        end else if (unlock_rise) begin
          state_d = OPEN;
          tmr_d   = UNLOCK_LOAD;
        end else if (change_rise) begin
          pw_d = new_password;
        end
      end
      OPEN: begin
        if (ms_rise) begin
          state_d = ENTRY;
          tmr_d   = '0;
        end else if (unlock_rise) begin
          tmr_d = UNLOCK_LOAD;
        end else if (tmr_q == '0) begin
          state_d = MENU;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ALARM: begin
`ifdef DOOR_ALARM_LOCKOUT_EN
        if (tmr_q == '0) begin
          state_d = ENTRY;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
`endif
      end
      default: state_d = ENTRY;
    endcase
  end

  // Outputs decode the state register, so they trail a state change by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ENTRY;
      tmr_q         <= '0;
      cnt_q         <= '0;
      pw_q          <= DEFAULT_PW;
      unlock_signal <= 1'b0;
      lock_signal   <= 1'b1;
      alarm_signal  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      cnt_q         <= cnt_d;
      pw_q          <= pw_d;
      unlock_signal <= (state_q == OPEN);
      lock_signal   <= (state_q != OPEN);
      alarm_signal  <= (state_q == ALARM);
    end
  end

  assign fail_count = cnt_q;

endmodule
